// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator: default accumulator width,
// channel configuration record and a frequency-to-increment helper.
package tick_pkg;

    localparam int ACC_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic                         en;
        logic [ACC_WIDTH_DEFAULT-1:0] inc;
    } tick_cfg_t;

    // Rounded phase increment giving f_out from f_clk, for building DEFAULT_INC.
    function automatic logic [ACC_WIDTH_DEFAULT-1:0] freq_to_inc(
        input longint unsigned f_out,
        input longint unsigned f_clk
    );
        longint unsigned scaled;
        scaled = ((f_out << ACC_WIDTH_DEFAULT) + (f_clk >> 1)) / f_clk;
        return ACC_WIDTH_DEFAULT'(scaled);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One phase-accumulator channel: holds its own enable/increment, emits a
// registered tick on accumulator overflow and a toggle that flips per tick.
module tick_channel
    import tick_pkg::*;
#(
    parameter int                   ACC_WIDTH   = ACC_WIDTH_DEFAULT,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = '0,
    parameter logic                 DEFAULT_EN  = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 cfg_en,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic                 en,
    output logic [ACC_WIDTH-1:0] inc,
    output logic                 tick,
    output logic                 toggle
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    // The extra top bit of the sum is the overflow carry that becomes the tick.
    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            en     <= DEFAULT_EN;
            inc    <= DEFAULT_INC;
            tick   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            if (load) begin
                en  <= cfg_en;
                inc <= cfg_inc;
            end
            // A reconfiguration or resync restarts the phase from zero.
            if (load || clear) begin
                acc    <= '0;
                tick   <= 1'b0;
                toggle <= 1'b0;
            end else if (en) begin
                acc  <= sum[ACC_WIDTH-1:0];
                tick <= sum[ACC_WIDTH];
                if (sum[ACC_WIDTH]) begin
                    toggle <= ~toggle;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: decodes configuration writes,
// flags writes to missing channels and provides registered readback.
module tick_gen
    import tick_pkg::*;
#(
    parameter int                            CHANNELS    = 4,
    parameter int                            ACC_WIDTH   = ACC_WIDTH_DEFAULT,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] DEFAULT_INC = '0,
    parameter logic [CHANNELS-1:0]           DEFAULT_EN  = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic [3:0]           cfg_chan,
    input  logic                 cfg_en,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic                 cfg_error,
    input  logic                 resync,
    input  logic [3:0]           rd_chan,
    output logic                 rd_en,
    output logic [ACC_WIDTH-1:0] rd_inc,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  toggle
);

    logic [CHANNELS-1:0]  load;
    logic [CHANNELS-1:0]  ch_en;
    logic [ACC_WIDTH-1:0] ch_inc [CHANNELS];
    logic                 cfg_bad;
    logic                 sel_en;
    logic [ACC_WIDTH-1:0] sel_inc;

    assign cfg_bad = cfg_valid && (int'(cfg_chan) >= CHANNELS);

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
        assign load[g] = cfg_valid && (cfg_chan == 4'(g));

        tick_channel #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DEFAULT_INC(DEFAULT_INC[g*ACC_WIDTH +: ACC_WIDTH]),
            .DEFAULT_EN (DEFAULT_EN[g])
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .load   (load[g]),
            .clear  (resync),
            .cfg_en (cfg_en),
            .cfg_inc(cfg_inc),
            .en     (ch_en[g]),
            .inc    (ch_inc[g]),
            .tick   (tick[g]),
            .toggle (toggle[g])
        );
    end

    // Out-of-range readback selects fall through to zero.
    always_comb begin
        sel_en  = 1'b0;
        sel_inc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_chan == 4'(i)) begin
                sel_en  = ch_en[i];
                sel_inc = ch_inc[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_error <= 1'b0;
            rd_en     <= 1'b0;
            rd_inc    <= '0;
        end else begin
            cfg_error <= cfg_bad;
            rd_en     <= sel_en;
            rd_inc    <= sel_inc;
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Randomized scoreboard bench for tick_gen: a phase-arithmetic model predicts
// every cycle's outputs, and a separate monitor compares them against the DUT.
module tb_tick_gen;
    import tick_pkg::*;

    localparam int CH = 4;
    localparam int AW = 32;
    localparam logic [CH*AW-1:0] DEF_INC = {32'h0, 32'h0, 32'h0, 32'h8000_0000};
    localparam logic [CH-1:0]    DEF_EN  = 4'b0001;
    localparam longint unsigned  MOD     = 64'h1_0000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [3:0]    cfg_chan;
    logic          cfg_en;
    logic [AW-1:0] cfg_inc;
    logic          cfg_error;
    logic          resync;
    logic [3:0]    rd_chan;
    logic          rd_en;
    logic [AW-1:0] rd_inc;
    logic [CH-1:0] tick;
    logic [CH-1:0] toggle;

    tick_gen #(
        .CHANNELS   (CH),
        .ACC_WIDTH  (AW),
        .DEFAULT_INC(DEF_INC),
        .DEFAULT_EN (DEF_EN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_chan (cfg_chan),
        .cfg_en   (cfg_en),
        .cfg_inc  (cfg_inc),
        .cfg_error(cfg_error),
        .resync   (resync),
        .rd_chan  (rd_chan),
        .rd_en    (rd_en),
        .rd_inc   (rd_inc),
        .tick     (tick),
        .toggle   (toggle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CH-1:0] tick;
        logic [CH-1:0] toggle;
        logic          err;
        logic          rd_en;
        logic [AW-1:0] rd_inc;
        bit            watch;
    } exp_t;

    exp_t sb[$];

    longint unsigned m_acc [CH];
    tick_cfg_t       m_cfg [CH];
    logic            m_tick[CH];
    logic            m_tog [CH];
    logic            m_err;
    logic            m_rd_en;
    logic [AW-1:0]   m_rd_inc;

    int checks = 0;
    int fails  = 0;
    bit started = 0;
    bit watch = 0;
    int wch = 0;
    int cyc = 0;
    int obs_cnt, last_tick, min_gap, max_gap;

    // Reference behaviour: phase arithmetic modulo 2^32, overflow means a tick.
    task automatic model_edge();
        longint unsigned s;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i]     = 0;
                m_cfg[i].inc = DEF_INC[i*AW +: AW];
                m_cfg[i].en  = DEF_EN[i];
                m_tick[i]    = 1'b0;
                m_tog[i]     = 1'b0;
            end
            m_err    = 1'b0;
            m_rd_en  = 1'b0;
            m_rd_inc = '0;
        end else begin
            if (int'(rd_chan) < CH) begin
                m_rd_en  = m_cfg[int'(rd_chan)].en;
                m_rd_inc = m_cfg[int'(rd_chan)].inc;
            end else begin
                m_rd_en  = 1'b0;
                m_rd_inc = '0;
            end
            m_err = cfg_valid && (int'(cfg_chan) >= CH);
            for (int i = 0; i < CH; i++) begin
                if (cfg_valid && int'(cfg_chan) == i) begin
                    m_cfg[i].en  = cfg_en;
                    m_cfg[i].inc = cfg_inc;
                    m_acc[i]     = 0;
                    m_tick[i]    = 1'b0;
                    m_tog[i]     = 1'b0;
                end else if (resync) begin
                    m_acc[i]  = 0;
                    m_tick[i] = 1'b0;
                    m_tog[i]  = 1'b0;
                end else if (m_cfg[i].en) begin
                    s         = m_acc[i] + longint'(m_cfg[i].inc);
                    m_tick[i] = (s >= MOD);
                    m_acc[i]  = s % MOD;
                    if (m_tick[i]) m_tog[i] = !m_tog[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
        end
    endtask

    // Inputs are already set; predict the post-edge outputs and advance one cycle.
    task automatic step();
        exp_t e;
        model_edge();
        for (int i = 0; i < CH; i++) begin
            e.tick[i]   = m_tick[i];
            e.toggle[i] = m_tog[i];
        end
        e.err    = m_err;
        e.rd_en  = m_rd_en;
        e.rd_inc = m_rd_inc;
        e.watch  = watch;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic set_idle();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = 4'd0;
        cfg_en    = 1'b0;
        cfg_inc   = '0;
        resync    = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            rd_chan = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    task automatic cfg_write(input int ch, input logic en, input logic [AW-1:0] inc);
        set_idle();
        cfg_valid = 1'b1;
        cfg_chan  = 4'(ch);
        cfg_en    = en;
        cfg_inc   = inc;
        step();
        set_idle();
    endtask

    task automatic apply_stimulus(input int n);
        for (int k = 0; k < n; k++) begin
            reset     = ($urandom_range(0, 199) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_chan  = 4'($urandom_range(0, 5));
            cfg_en    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       cfg_inc = 32'h8000_0000 >> $urandom_range(0, 4);
                1:       cfg_inc = $urandom;
                2:       cfg_inc = '0;
                default: cfg_inc = $urandom & 32'h0FFF_FFFF;
            endcase
            resync  = ($urandom_range(0, 49) == 0);
            rd_chan = 4'($urandom_range(0, 15));
            step();
        end
        set_idle();
    endtask

    task automatic run_window(input int ch, input logic [AW-1:0] inc, input int n);
        cfg_write(ch, 1'b1, inc);
        wch       = ch;
        obs_cnt   = 0;
        last_tick = -1;
        min_gap   = 1000000000;
        max_gap   = 0;
        watch     = 1;
        idle_steps(n);
        watch     = 0;
        idle_steps(2);
    endtask

    task automatic check_value(input string name, input longint unsigned got, input longint unsigned want);
        checks++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_output(input exp_t e);
        checks++;
        if ({tick, toggle} !== {e.tick, e.toggle}) begin
            fails++;
            $display("[TB] FAIL tick_toggle @%0t: got tick=%b toggle=%b, expected tick=%b toggle=%b",
                     $time, tick, toggle, e.tick, e.toggle);
        end
        checks++;
        if (cfg_error !== e.err) begin
            fails++;
            $display("[TB] FAIL cfg_error @%0t: got %b, expected %b", $time, cfg_error, e.err);
        end
        checks++;
        if ({rd_en, rd_inc} !== {e.rd_en, e.rd_inc}) begin
            fails++;
            $display("[TB] FAIL readback @%0t: got en=%b inc=%h, expected en=%b inc=%h",
                     $time, rd_en, rd_inc, e.rd_en, e.rd_inc);
        end
        if (e.watch && tick[wch] === 1'b1) begin
            obs_cnt++;
            if (last_tick >= 0) begin
                if (cyc - last_tick < min_gap) min_gap = cyc - last_tick;
                if (cyc - last_tick > max_gap) max_gap = cyc - last_tick;
            end
            last_tick = cyc;
        end
    endtask

    // Monitor: one expected entry per clock edge, compared after the edge settles.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (started) begin
                cyc++;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard_empty @%0t: got 0 entries, expected 1", $time);
                end else begin
                    check_output(sb.pop_front());
                end
            end
        end
    end

    initial begin
        longint unsigned expected_cnt;
        set_idle();
        reset   = 1'b1;
        rd_chan = 4'd0;
        started = 1;

        repeat (3) step();
        idle_steps(20);

        cfg_write(1, 1'b1, 32'h4000_0000);
        rd_chan = 4'd1;
        step();
        idle_steps(20);

        cfg_write(CH, 1'b1, 32'h1234_5678);
        for (int i = 0; i < CH; i++) begin
            rd_chan = 4'(i);
            step();
        end
        cfg_write(0, 1'b0, 32'h8000_0000);
        idle_steps(100);

        cfg_write(0, 1'b1, 32'h8000_0000);
        idle_steps(7);
        resync = 1'b1;
        step();
        idle_steps(12);

        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan  = 4'd1;
        cfg_en    = 1'b1;
        cfg_inc   = 32'hDEAD_BEEF;
        resync    = 1'b1;
        step();
        for (int i = 0; i < CH; i++) begin
            set_idle();
            rd_chan = 4'(i);
            step();
        end
        idle_steps(6);

        run_window(2, 32'd1407375, 20000);
        expected_cnt = (longint'(20000) * longint'(32'd1407375)) >> 32;
        check_value("ch2_tick_count", longint'(obs_cnt), expected_cnt);
        check_value("ch2_min_spacing", longint'(min_gap), MOD / 64'd1407375);
        check_value("ch2_max_spacing", longint'(max_gap), (MOD + 64'd1407374) / 64'd1407375);

        run_window(3, 32'd4947802, 20000);
        expected_cnt = (longint'(20000) * longint'(32'd4947802)) >> 32;
        check_value("ch3_tick_count", longint'(obs_cnt), expected_cnt);

        check_value("freq_to_inc_32768", longint'(freq_to_inc(64'd32768, 64'd100_000_000)), 64'd1407375);
        check_value("freq_to_inc_115200", longint'(freq_to_inc(64'd115200, 64'd100_000_000)), 64'd4947802);

        apply_stimulus(4000);
        idle_steps(5);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
        started = 0;
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Multi-channel, runtime-programmable tick/enable generator; replaces fixed integer clock dividers (PLL, RTC, UART bit clock) computed from static clock frequencies.
- Each channel is a phase accumulator: fractional frequency ratios (e.g. 32768 Hz from 100 MHz) carry no cumulative error.
- Sits beside the CLINT/UART in the SoC and feeds one-cycle tick enables and square-wave toggles to peripherals.

Parameters:
- CHANNELS, 4, number of independent tick channels (1..16).
- ACC_WIDTH, 32, accumulator/increment width in bits.
- DEFAULT_INC, {CHANNELS{32'h0}}, per-channel increment loaded at reset.
- DEFAULT_EN, {CHANNELS{1'b0}}, per-channel enable loaded at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration write strobe, single cycle, no backpressure
- cfg_chan  in  4  target channel
- cfg_en  in  1  channel enable value
- cfg_inc  in  ACC_WIDTH  increment value
- cfg_error  out  1  one-cycle pulse: write to cfg_chan >= CHANNELS
- resync  in  1  zero all accumulators and toggles together
- rd_chan  in  4  readback channel select
- rd_en  out  1  registered enable of rd_chan (0 if out of range)
- rd_inc  out  ACC_WIDTH  registered increment of rd_chan (0 if out of range)
- tick  out  CHANNELS  one-cycle pulse per accumulator overflow
- toggle  out  CHANNELS  flips on every tick (square wave at f_tick/2)

Behaviour:
- Reset (synchronous, sampled on a rising clock edge): acc=0, inc=DEFAULT_INC[i], en=DEFAULT_EN[i], tick=0, toggle=0, cfg_error=0, rd_en=0, rd_inc=0.
  - Reset asserted mid-operation wins over cfg_valid and resync in the same cycle.
- Per edge, enabled channel: {carry, acc} <= acc + inc (ACC_WIDTH+1-bit sum, wrap modulo 2^ACC_WIDTH); tick[i] <= carry.
  - Tick is registered and visible one cycle after the overflowing accumulation.
  - On a tick, toggle[i] <= ~toggle[i].
  - Output frequency = f_clk * inc / 2^ACC_WIDTH.
  - inc=0 never ticks. inc=2^(ACC_WIDTH-1) ticks every 2nd cycle.
- Disabled channel (en=0): acc and toggle hold, tick=0.
- Config write (cfg_valid, cfg_chan<CHANNELS):
  - inc/en of that channel updated at the edge; acc cleared, toggle cleared, tick forced 0 for that edge.
  - Other channels are unaffected.
- Config write with cfg_chan>=CHANNELS: no state change; cfg_error=1 for the following cycle.
- resync=1: all acc=0, toggle=0, tick=0 at the edge. en/inc unchanged.
- resync together with cfg_valid: both apply (new inc/en, acc=0).
- Readback: rd_en/rd_inc reflect rd_chan's current registers with 1-cycle latency.
  - A write and a read of the same channel in one cycle returns the old value; the new value appears next cycle.
- No state machine beyond per-channel accumulator/enable/toggle registers.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package tick_pkg:
  - ACC_WIDTH default.
  - typedef tick_cfg_t {logic en; logic [ACC_WIDTH-1:0] inc;}.
  - Constant function freq_to_inc(f_out, f_clk) = round(f_out*2^ACC_WIDTH/f_clk), used for DEFAULT_INC at SoC level.
- One sub-module tick_channel: accumulator, carry/tick register, toggle, local clear.
  - Instantiated CHANNELS times by generate.
  - Top holds cfg decode, error flag and readback mux.

Test Plan:
- DEFAULT_INC[0]=32'h8000_0000, DEFAULT_EN[0]=1, release reset → tick[0] high every 2nd cycle, toggle[0] period 4 cycles; all other ticks stay 0.
- cfg write ch2 inc=1407375 (32768 Hz at 100 MHz), en=1; run 10,000,000 cycles → exactly 3276 tick[2] pulses; max spacing 3052, min spacing 3051 cycles.
- cfg write ch3 inc=4947802 (115200 baud); run 100,000 cycles → exactly 115 tick[3] pulses.
- cfg write ch1 inc=32'h4000_0000 en=1 in cycle 0 → tick[1] first high in cycle 5, then every 4th cycle; rd_chan=1 the next cycle → rd_inc=32'h4000_0000, rd_en=1.
- Write cfg_chan=CHANNELS → cfg_error pulses one cycle; rd of all channels unchanged. Write ch0 en=0 → tick[0]=0, toggle[0] frozen for 100 cycles.
- Channels 0,1 running; assert resync → both acc=0, toggles 0, then ticks phase-aligned. Assert reset mid-run with cfg_valid high → all outputs at reset values next cycle, inc back to DEFAULT_INC.
